hidden_layer_sequencer: RTL and testbench

Time-multiplexed controller for the fully connected hidden layer of the MNIST inference datapath. On `start` it runs one layer pass neuron by neuron:
- clears the shared MAC accumulator;
- streams all input-pixel weight reads through the weight ROM, then one bias read;
- strobes MAC valid and waits for the ReLU result;
- writes the result into the layer result buffer.

It sits between the top-level inference FSM (start/done) and the MAC/ReLU/ROM datapath.

---
 rtl/nn_pkg.sv | 19 +
 rtl/hidden_layer_sequencer.sv | 103 ++++++++++
 tb/tb_hidden_layer_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared types and layer constants for the MNIST inference datapath.
package nn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        BIAS,
        DRAIN,
        VALID,
        WAIT,
        DONE
    } seq_state_t;

    localparam int N_IN_HIDDEN = 784;
    localparam int N_HIDDEN    = 10;
    localparam int DW          = 16;

endpackage

// File: rtl/hidden_layer_sequencer.sv
// Neuron-by-neuron sequencer for the hidden layer: clear, stream weights,
// add bias, fire the ReLU and store each result.
module hidden_layer_sequencer #(
    parameter int N_IN  = nn_pkg::N_IN_HIDDEN,
    parameter int N_OUT = nn_pkg::N_HIDDEN,
    parameter int DW    = nn_pkg::DW,
    localparam int AW   = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
    localparam int NW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          rom_ready,
    output logic          busy,
    output logic          done,
    output logic          rom_rd,
    output logic [AW-1:0] rom_addr,
    output logic          bias_rd,
    output logic [NW-1:0] neuron_idx,
    output logic          mac_clear,
    output logic          mac_en,
    output logic          mac_bias_en,
    output logic          mac_valid,
    input  logic          relu_valid,
    input  logic [DW-1:0] relu_out,
    output logic          result_wr,
    output logic [NW-1:0] result_idx,
    output logic [DW-1:0] result_data
);
    import nn_pkg::*;

    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [IW-1:0] LAST_IN  = IW'(N_IN - 1);
    localparam logic [NW-1:0] LAST_OUT = NW'(N_OUT - 1);

    seq_state_t    state;
    logic [IW-1:0] in_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            neuron_idx  <= '0;
            in_idx      <= '0;
            mac_en      <= 1'b0;
            mac_bias_en <= 1'b0;
        end else begin
            // ROM data lands one cycle after the read strobe
            mac_en      <= rom_rd;
            mac_bias_en <= bias_rd;
            if (abort) begin
                state      <= IDLE;
                neuron_idx <= '0;
                in_idx     <= '0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        state      <= CLEAR;
                        neuron_idx <= '0;
                    end
                    CLEAR: begin
                        in_idx <= '0;
                        state  <= ACCUM;
                    end
                    ACCUM: if (rom_ready) begin
                        if (in_idx == LAST_IN) state <= BIAS;
                        else                   in_idx <= in_idx + IW'(1);
                    end
                    BIAS:  state <= DRAIN;
                    DRAIN: state <= VALID;
                    VALID: state <= WAIT;
                    WAIT: if (relu_valid) begin
                        if (neuron_idx == LAST_OUT) begin
                            state <= DONE;
                        end else begin
                            neuron_idx <= neuron_idx + NW'(1);
                            state      <= CLEAR;
                        end
                    end
                    DONE: begin
                        state      <= IDLE;
                        neuron_idx <= '0;
                        in_idx     <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Strobes decode straight from the state register; rom_rd also gates on ready
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign mac_clear   = (state == CLEAR);
    assign rom_rd      = (state == ACCUM) && rom_ready;
    assign bias_rd     = (state == BIAS);
    assign mac_valid   = (state == VALID);
    assign result_wr   = (state == WAIT) && relu_valid;
    assign result_idx  = neuron_idx;
    assign result_data = relu_out;
    assign rom_addr    = AW'(neuron_idx) * AW'(N_IN) + AW'(in_idx);

endmodule

// File: tb/tb_hidden_layer_sequencer.sv
// Scoreboard bench: a small 4x2 instance for the scenarios and a default-size instance.
module tb_hidden_layer_sequencer;
    localparam int NI  = 4;
    localparam int NO  = 2;
    localparam int BNI = 784;
    localparam int BNO = 10;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // small instance
    logic        start = 0, abort = 0, rom_ready = 1;
    logic        relu_m = 0, relu_inj = 0, relu_v;
    logic [15:0] relu_out = '0;
    logic        busy, done, rom_rd, bias_rd, mac_clear, mac_en, mac_bias_en, mac_valid, result_wr;
    logic [2:0]  rom_addr;
    logic        neuron_idx, result_idx;
    logic [15:0] result_data;
    assign relu_v = relu_m | relu_inj;

    hidden_layer_sequencer #(.N_IN(NI), .N_OUT(NO), .DW(16)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .rom_ready(rom_ready),
        .busy(busy), .done(done), .rom_rd(rom_rd), .rom_addr(rom_addr), .bias_rd(bias_rd),
        .neuron_idx(neuron_idx), .mac_clear(mac_clear), .mac_en(mac_en),
        .mac_bias_en(mac_bias_en), .mac_valid(mac_valid), .relu_valid(relu_v),
        .relu_out(relu_out), .result_wr(result_wr), .result_idx(result_idx),
        .result_data(result_data)
    );

    // default-size instance
    logic        b_start = 0, b_abort = 0, b_rom_ready = 1, b_relu_valid = 0;
    logic [15:0] b_relu_out = 16'h0100;
    logic        b_busy, b_done, b_rom_rd, b_bias_rd, b_mac_clear, b_mac_en, b_mac_bias_en;
    logic        b_mac_valid, b_result_wr;
    logic [12:0] b_rom_addr;
    logic [3:0]  b_neuron_idx, b_result_idx;
    logic [15:0] b_result_data;

    hidden_layer_sequencer dut_big (
        .clk(clk), .reset(reset), .start(b_start), .abort(b_abort), .rom_ready(b_rom_ready),
        .busy(b_busy), .done(b_done), .rom_rd(b_rom_rd), .rom_addr(b_rom_addr),
        .bias_rd(b_bias_rd), .neuron_idx(b_neuron_idx), .mac_clear(b_mac_clear),
        .mac_en(b_mac_en), .mac_bias_en(b_mac_bias_en), .mac_valid(b_mac_valid),
        .relu_valid(b_relu_valid), .relu_out(b_relu_out), .result_wr(b_result_wr),
        .result_idx(b_result_idx), .result_data(b_result_data)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    typedef struct {
        int          idx;
        logic [15:0] data;
    } res_t;

    int   addr_q[$];
    res_t res_q[$];
    res_t r;
    logic [15:0] relu_tbl [NO] = '{16'h0011, 16'h0022};

    int n_rd = 0, n_rd_stall = 0, n_men = 0, n_men_nrn = 0, n_mv = 0, n_wr = 0, n_done = 0;
    int lat = 1, pass_id = 0;
    int m_pass = 0, m_nrn = 0, m_cnt = 0;
    logic mv;

    // ReLU model: result appears `lat` cycles after mac_valid; expected write queued as it is driven
    always @(posedge clk) begin
        mv = mac_valid;
        #1;
        relu_m = 1'b0;
        if (m_pass != pass_id) begin
            m_pass = pass_id;
            m_nrn  = 0;
            m_cnt  = 0;
        end
        if (mv) m_cnt = lat;
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                relu_out = relu_tbl[m_nrn % NO];
                res_q.push_back('{m_nrn, relu_out});
                relu_m = 1'b1;
                m_nrn++;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (rom_rd) begin
                n_rd++;
                if (!rom_ready) n_rd_stall++;
                if (addr_q.size() == 0) chk("rom_rd_unexpected", addr_q.size(), 1);
                else chk("rom_addr", rom_addr, addr_q.pop_front());
            end
            if (mac_clear) n_men_nrn = 0;
            if (mac_en) begin
                n_men++;
                n_men_nrn++;
            end
            if (mac_valid) begin
                n_mv++;
                chk("mac_en_per_neuron", n_men_nrn, NI);
            end
            if (result_wr) begin
                n_wr++;
                if (res_q.size() == 0) chk("result_wr_unexpected", res_q.size(), 1);
                else begin
                    r = res_q.pop_front();
                    chk("result_idx", result_idx, r.idx);
                    chk("result_data", result_data, r.data);
                end
            end
            if (done) n_done++;
        end
    end

    // default-size ReLU: one-cycle latency
    logic bmv;
    int   b_nrd = 0, b_nwr = 0, b_addr_err = 0, b_exp_addr = 0;
    logic [12:0] b_last = '0;
    always @(posedge clk) begin
        bmv = b_mac_valid;
        #1;
        b_relu_valid = bmv;
    end
    always @(negedge clk) begin
        if (reset) begin
            if (b_rom_rd) begin
                b_nrd++;
                if (int'(b_rom_addr) != b_exp_addr) b_addr_err++;
                b_exp_addr++;
                b_last = b_rom_addr;
            end
            if (b_result_wr) b_nwr++;
        end
    end

    task automatic run_pass(input string nm, input int exp_done, input int stall_at,
                            input int stall_len, input int abort_at, input int inj_at,
                            input int start_at, input int rst_at);
        int n, rd0, men0, mv0, wr0, dn0, st0;
        rd0 = n_rd; men0 = n_men; mv0 = n_mv; wr0 = n_wr; dn0 = n_done; st0 = n_rd_stall;
        pass_id++;
        addr_q.delete();
        res_q.delete();
        for (int a = 0; a < NI * NO; a++) addr_q.push_back(a);
        rom_ready = 1;
        @(posedge clk); #1;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        n = 1;
        while (n < 200) begin
            rom_ready = !(stall_at > 0 && n >= stall_at && n < stall_at + stall_len);
            abort     = (n == abort_at);
            start     = (n == start_at);
            relu_inj  = (n == inj_at);
            if (n == rst_at) begin
                chk({nm, "_bias_rd_before_rst"}, bias_rd, 1);
                #2 reset = 0;
                #1 chk({nm, "_async_rst_outs"},
                       {busy, done, rom_rd, bias_rd, mac_clear, mac_en, mac_bias_en,
                        mac_valid, result_wr, rom_addr, neuron_idx, result_idx}, 0);
                break;
            end
            @(negedge clk);
            if (abort_at > 0 && n == abort_at + 1) begin
                chk({nm, "_abort_busy"}, busy, 0);
                break;
            end
            if (done) break;
            @(posedge clk); #1;
            n++;
        end
        abort = 0; start = 0; relu_inj = 0; rom_ready = 1;
        if (rst_at > 0) begin
            repeat (2) @(posedge clk);
            #1 chk({nm, "_rst_held_busy"}, busy, 0);
            chk({nm, "_rst_no_done"}, n_done - dn0, 0);
            reset = 1;
            addr_q.delete();
            res_q.delete();
            return;
        end
        if (abort_at > 0) begin
            repeat (30) @(posedge clk);
            #1 chk({nm, "_abort_no_done"}, n_done - dn0, 0);
            chk({nm, "_abort_neuron_idx"}, neuron_idx, 0);
            addr_q.delete();
            res_q.delete();
            return;
        end
        chk({nm, "_done_cycle"}, n, exp_done);
        chk({nm, "_rom_rd_count"}, n_rd - rd0, NI * NO);
        chk({nm, "_rd_in_stall"}, n_rd_stall - st0, 0);
        chk({nm, "_mac_en_count"}, n_men - men0, NI * NO);
        chk({nm, "_mac_valid_count"}, n_mv - mv0, NO);
        chk({nm, "_result_wr_count"}, n_wr - wr0, NO);
        chk({nm, "_pending_results"}, res_q.size(), 0);
        chk({nm, "_pending_addrs"}, addr_q.size(), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({nm, "_done_one_cycle"}, done, 0);
        chk({nm, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        int n;
        #2;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_strobes", {rom_rd, bias_rd, mac_clear, mac_en, mac_bias_en, mac_valid}, 0);
        chk("reset_addr_idx", {rom_addr, neuron_idx, result_idx}, 0);
        @(posedge clk); #1 reset = 1;
        repeat (2) @(posedge clk);

        lat = 1;
        run_pass("s1_basic", 19, 0, 0, 0, 0, 0, 0);
        run_pass("s2_stall", 22, 3, 3, 0, 0, 0, 0);
        lat = 4;
        run_pass("s3_relu_lat4", 25, 0, 0, 0, 0, 0, 0);
        lat = 1;
        run_pass("s4_abort", 0, 0, 0, 12, 0, 0, 0);
        run_pass("s4_after_abort", 19, 0, 0, 0, 0, 0, 0);
        run_pass("s5_reset", 0, 0, 0, 0, 0, 0, 6);
        repeat (2) @(posedge clk);
        run_pass("s5_after_reset", 19, 0, 0, 0, 0, 0, 0);
        run_pass("s6_ignored", 19, 0, 0, 0, 3, 4, 0);

        @(posedge clk); #1 b_start = 1;
        @(posedge clk); #1 b_start = 0;
        n = 1;
        while (n < 9000) begin
            @(negedge clk);
            if (b_done) break;
            @(posedge clk); #1;
            n++;
        end
        chk("s7_done_cycle", n, 7891);
        chk("s7_rom_rd_count", b_nrd, BNI * BNO);
        chk("s7_last_addr", b_last, 7839);
        chk("s7_addr_sequence_errs", b_addr_err, 0);
        chk("s7_result_wr_count", b_nwr, BNO);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
